// File: rtl/filt_arith_core.sv
// Arithmetic primitives for the fixed-point IIR datapath: a registered signed
// 8x8 multiplier plus independent 16-bit and 8-bit ripple-carry adders.

module ripple_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

module filt_arith_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  mul_a,
  input  logic [7:0]  mul_b,
  output logic [15:0] mul_p,
  input  logic [15:0] add16_a,
  input  logic [15:0] add16_b,
  input  logic        add16_cin,
  output logic [15:0] add16_sum,
  output logic        add16_cout,
  input  logic [7:0]  add8_a,
  input  logic [7:0]  add8_b,
  input  logic        add8_cin,
  output logic [7:0]  add8_sum,
  output logic        add8_cout
);

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] pp [OP_W];
  logic [PROD_W-1:0] prod_c;

  assign a_ext = {{(PROD_W - OP_W){mul_a[OP_W-1]}}, mul_a};

  // Sign-extended partial products; the MSB row of a signed multiplier has
  // negative weight, so it is two's-complement negated before reduction.
  for (genvar i = 0; i < int'(OP_W); i++) begin : g_pp
    if (i == int'(OP_W) - 1) begin : g_neg
      assign pp[i] = mul_b[i] ? PROD_W'(~(a_ext << i) + PROD_W'(1)) : '0;
    end else begin : g_pos
      assign pp[i] = mul_b[i] ? PROD_W'(a_ext << i) : '0;
    end
  end

  always_comb begin
    prod_c = '0;
    for (int i = 0; i < int'(OP_W); i++) begin
      prod_c = PROD_W'(prod_c + pp[i]);
    end
  end

  // Product register: one-cycle latency, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_p <= '0;
    end else begin
      mul_p <= prod_c;
    end
  end

  ripple_add #(.WIDTH(16)) u_add16 (
    .a    (add16_a),
    .b    (add16_b),
    .cin  (add16_cin),
    .sum  (add16_sum),
    .cout (add16_cout)
  );

  ripple_add #(.WIDTH(8)) u_add8 (
    .a    (add8_a),
    .b    (add8_b),
    .cin  (add8_cin),
    .sum  (add8_sum),
    .cout (add8_cout)
  );

endmodule

// File: tb/tb_filt_arith_core.sv
// Scoreboard bench for filt_arith_core: expected products/sums are queued
// when stimulus is driven and compared when the DUT output is valid.

module tb_filt_arith_core;

  logic        clk;
  logic        reset;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic [15:0] add16_a;
  logic [15:0] add16_b;
  logic        add16_cin;
  logic [15:0] add16_sum;
  logic        add16_cout;
  logic [7:0]  add8_a;
  logic [7:0]  add8_b;
  logic        add8_cin;
  logic [7:0]  add8_sum;
  logic        add8_cout;

  int unsigned n_vec;
  int unsigned n_err;

  logic [15:0] mul_q  [$];
  logic [16:0] add16_q[$];
  logic [8:0]  add8_q [$];

  filt_arith_core dut (
    .clk        (clk),
    .reset      (reset),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .add16_a    (add16_a),
    .add16_b    (add16_b),
    .add16_cin  (add16_cin),
    .add16_sum  (add16_sum),
    .add16_cout (add16_cout),
    .add8_a     (add8_a),
    .add8_b     (add8_b),
    .add8_cin   (add8_cin),
    .add8_sum   (add8_sum),
    .add8_cout  (add8_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 16'(p);
  endfunction

  // Drive one multiplier operand pair, queue its product, check after the edge
  task automatic mul_step(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] e;
    @(negedge clk);
    mul_a = a;
    mul_b = b;
    mul_q.push_back(model_mul(a, b));
    @(posedge clk);
    #1;
    if (mul_q.size() == 0) begin
      check("mul_q_empty", 32'd1, 32'd0);
    end else begin
      e = mul_q.pop_front();
      check("mul_p", 32'(mul_p), 32'(e));
    end
  endtask

  task automatic add16_step(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] e;
    add16_a   = a;
    add16_b   = b;
    add16_cin = c;
    add16_q.push_back(17'(32'(a) + 32'(b) + 32'(c)));
    #1;
    e = add16_q.pop_front();
    check("add16", 32'({add16_cout, add16_sum}), 32'(e));
  endtask

  task automatic add8_step(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] e;
    add8_a   = a;
    add8_b   = b;
    add8_cin = c;
    add8_q.push_back(9'(32'(a) + 32'(b) + 32'(c)));
    #1;
    e = add8_q.pop_front();
    check("add8", 32'({add8_cout, add8_sum}), 32'(e));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    mul_a     = 8'h7F;
    mul_b     = 8'h7F;
    add16_a   = '0;
    add16_b   = '0;
    add16_cin = 1'b0;
    add8_a    = '0;
    add8_b    = '0;
    add8_cin  = 1'b0;

    // Reset held while clocking: product register stays clear
    repeat (3) @(posedge clk);
    #1;
    check("mul_p_in_reset", 32'(mul_p), 32'h0000);

    @(negedge clk);
    reset = 1'b1;
    mul_q.push_back(16'h3F01);
    @(posedge clk);
    #1;
    check("mul_p_first", 32'(mul_p), 32'(mul_q.pop_front()));

    // Directed products, back to back
    mul_step(8'hEE, 8'h51);
    mul_step(8'h80, 8'h80);
    mul_step(8'hDE, 8'h40);
    mul_step(8'h80, 8'h7F);
    mul_step(8'hFF, 8'hFF);
    mul_step(8'h00, 8'hA5);
    mul_step(8'h5A, 8'h00);
    mul_step(8'h7F, 8'h80);

    // Adder16 carry corners
    add16_step(16'hFFFF, 16'h0001, 1'b0);
    add16_step(16'h7FFF, 16'h0001, 1'b0);
    add16_step(16'hFA4E, 16'hF780, 1'b1);
    add16_step(16'h0000, 16'h0000, 1'b1);
    add16_step(16'hFFFF, 16'hFFFF, 1'b1);

    // Adder8 rounding path
    add8_step(8'hF1, 8'h01, 1'b0);
    add8_step(8'hFF, 8'h00, 1'b1);
    add8_step(8'h7F, 8'h00, 1'b0);
    add8_step(8'hFF, 8'hFF, 1'b1);

    // Async reset between edges while a nonzero product is held
    mul_step(8'h12, 8'h34);
    #2;
    reset = 1'b0;
    #1;
    check("mul_p_async_clr", 32'(mul_p), 32'h0000);
    add16_step(16'h1234, 16'h4321, 1'b1);
    add8_step(8'h80, 8'h80, 1'b0);
    @(posedge clk);
    #1;
    check("mul_p_held_clr", 32'(mul_p), 32'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Random traffic on all three units
    for (int i = 0; i < 40; i++) begin
      mul_step(8'($urandom), 8'($urandom));
      add16_step(16'($urandom), 16'($urandom), 1'($urandom));
      add8_step(8'($urandom), 8'($urandom), 1'($urandom));
    end

    check("scoreboard_drained", 32'(mul_q.size() + add16_q.size() + add8_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
